// File: rtl/hub_pkg.sv
// Shared hub definitions: slot geometry and one-hot/index helpers.
package hub_pkg;

    localparam int HUB_SLOTS = 8;
    localparam int SLOT_W    = 3;

    typedef logic [SLOT_W-1:0]    slot_idx_t;
    typedef logic [HUB_SLOTS-1:0] slot_mask_t;

    // Binary slot index to one-hot select.
    function automatic slot_mask_t idx_to_onehot(input slot_idx_t idx);
        return slot_mask_t'(1) << idx;
    endfunction

    // One-hot select to binary index; all-zero input gives index 0.
    function automatic slot_idx_t onehot_to_idx(input slot_mask_t oh);
        slot_idx_t idx;
        idx = '0;
        for (int i = 0; i < HUB_SLOTS; i++) begin
            if (oh[i]) idx = idx | slot_idx_t'(i);
        end
        return idx;
    endfunction

    // Mask of slots that physically exist for a given cog count.
    function automatic slot_mask_t populated_mask(input int num_cogs);
        slot_mask_t m;
        m = '0;
        for (int i = 0; i < HUB_SLOTS; i++) begin
            m[i] = (i < num_cogs);
        end
        return m;
    endfunction

endpackage

// File: rtl/hub_slot_sched_if.sv
// Control inputs and slot-select outputs of the hub slot scheduler.
interface hub_slot_sched_if;

    hub_pkg::slot_mask_t cog_ena;
    logic                skip_en_ovr;
    logic                skip_en_val;
    logic                hold;

    logic                ena_bus;
    hub_pkg::slot_mask_t bus_sel;
    hub_pkg::slot_idx_t  slot_num;
    logic                round_done;
    logic                slot_valid;

    // Scheduler side: consumes mode/hold controls, drives the slot strobes.
    modport master (
        input  cog_ena, skip_en_ovr, skip_en_val, hold,
        output ena_bus, bus_sel, slot_num, round_done, slot_valid
    );

    // Hub/cog side: drives controls, consumes the slot strobes.
    modport slave (
        output cog_ena, skip_en_ovr, skip_en_val, hold,
        input  ena_bus, bus_sel, slot_num, round_done, slot_valid
    );

endinterface

// File: rtl/hub_slot_sched_rr_next_finder.sv
// Circular search for the next eligible slot after the current one.
module rr_next_finder
    import hub_pkg::*;
(
    input  slot_idx_t  cur_idx,
    input  slot_mask_t elig,
    input  logic       from_reset,
    output slot_idx_t  nxt_idx,
    output logic       found
);

    slot_idx_t base;
    slot_idx_t cand;

    // Scan cur+1 .. cur+8 (wrapping, so cur itself is tried last);
    // from reset the scan starts at slot 0 instead.
    always_comb begin
        nxt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        base    = from_reset ? slot_idx_t'(0) : slot_idx_t'(cur_idx + slot_idx_t'(1));
        for (int k = 0; k < HUB_SLOTS; k++) begin
            cand = slot_idx_t'(base + slot_idx_t'(k));
            if (!found && elig[cand]) begin
                found   = 1'b1;
                nxt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/hub_slot_sched.sv
// Hub slot scheduler: phase strobe plus round-robin / skip-idle slot select.
module hub_slot_sched
    import hub_pkg::*;
#(
    parameter int NUM_COGS          = 8,
    parameter bit SKIP_IDLE_DEFAULT = 1'b0
) (
    input  logic             clk_cog,
    input  logic             nres,
    hub_slot_sched_if.master bus
);

    localparam slot_mask_t POP_MASK = populated_mask(NUM_COGS);
    localparam slot_idx_t  LAST_IDX = slot_idx_t'(NUM_COGS - 1);

    logic      phase_q, phase_d;
    slot_idx_t slot_q, slot_d;
    logic      valid_q, valid_d;
    logic      round_q, round_d;

    logic       skip_en;
    slot_mask_t elig;
    slot_idx_t  fnd_idx;
    logic       fnd;
    slot_idx_t  norm_idx;
    slot_idx_t  next_idx;

    rr_next_finder u_finder (
        .cur_idx    (slot_q),
        .elig       (elig),
        .from_reset (!valid_q),
        .nxt_idx    (fnd_idx),
        .found      (fnd)
    );

    // Mode muxing and candidate next slot; only consumed on advance edges.
    always_comb begin
        skip_en = bus.skip_en_ovr ? bus.skip_en_val : SKIP_IDLE_DEFAULT;
        elig    = bus.cog_ena & POP_MASK;
        if (!valid_q)
            norm_idx = '0;
        else if (slot_q == LAST_IDX)
            norm_idx = '0;
        else
            norm_idx = slot_idx_t'(slot_q + slot_idx_t'(1));
        // With nothing eligible, skip mode degrades to plain rotation.
        next_idx = (skip_en && fnd) ? fnd_idx : norm_idx;
    end

    // Next state: phase always toggles; slot moves only on an unheld advance.
    always_comb begin
        phase_d = ~phase_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        round_d = 1'b0;
        if (phase_q && !bus.hold) begin
            slot_d  = next_idx;
            valid_d = 1'b1;
            // A wrap (including staying put) or the first grant closes a round.
            round_d = !valid_q || (next_idx <= slot_q);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            phase_q <= 1'b0;
            slot_q  <= '0;
            valid_q <= 1'b0;
            round_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            round_q <= round_d;
        end
    end

    assign bus.ena_bus    = phase_q;
    assign bus.bus_sel    = valid_q ? idx_to_onehot(slot_q) : slot_mask_t'(0);
    assign bus.slot_num   = slot_q;
    assign bus.slot_valid = valid_q;
    assign bus.round_done = round_q;

endmodule

// File: tb/tb_hub_slot_sched.sv
// Scoreboard bench: stimulus queues expected slot state, a negedge monitor checks it.
module tb_hub_slot_sched;

    logic clk_cog;
    logic nres;

    hub_slot_sched_if if8 ();
    hub_slot_sched_if if3 ();

    hub_slot_sched #(.NUM_COGS(8), .SKIP_IDLE_DEFAULT(1'b0)) u_dut8 (
        .clk_cog (clk_cog),
        .nres    (nres),
        .bus     (if8)
    );

    hub_slot_sched #(.NUM_COGS(3), .SKIP_IDLE_DEFAULT(1'b0)) u_dut3 (
        .clk_cog (clk_cog),
        .nres    (nres),
        .bus     (if3)
    );

    typedef struct {
        int         dut;
        logic       ena;
        logic [7:0] sel;
        logic       rd;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   tag_n  = 0;

    initial begin
        clk_cog = 1'b0;
        forever #5 clk_cog = ~clk_cog;
    end

    function automatic logic [2:0] idx_of(input logic [7:0] s);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (s[i]) r = 3'(i);
        return r;
    endfunction

    task automatic push(input int dut, input logic e, input logic [7:0] s, input logic r);
        exp_t x;
        x.dut = dut; x.ena = e; x.sel = s; x.rd = r; x.tag = tag_n;
        tag_n++;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk_cog);
        #1;
    endtask

    // One slot period on the 8-cog instance: advance edge then phase edge.
    task automatic adv(input logic [7:0] s, input logic r);
        tick(); push(0, 1'b0, s, r);
        tick(); push(0, 1'b1, s, 1'b0);
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        exp_t       e;
        logic       a_ena, a_rd, a_vld, x_vld;
        logic [7:0] a_sel;
        logic [2:0] a_num, x_num;
        forever begin
            @(negedge clk_cog);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    a_ena = if8.ena_bus; a_sel = if8.bus_sel; a_num = if8.slot_num;
                    a_vld = if8.slot_valid; a_rd = if8.round_done;
                end else begin
                    a_ena = if3.ena_bus; a_sel = if3.bus_sel; a_num = if3.slot_num;
                    a_vld = if3.slot_valid; a_rd = if3.round_done;
                end
                x_num = idx_of(e.sel);
                x_vld = (e.sel != 8'h00);
                total++;
                if (a_ena === e.ena && a_sel === e.sel && a_num === x_num &&
                    a_vld === x_vld && a_rd === e.rd)
                    passed++;
                else
                    $display("FAIL chk%0d dut%0d: got ena=%b sel=%h num=%0d vld=%b rd=%b, want ena=%b sel=%h num=%0d vld=%b rd=%b",
                             e.tag, e.dut, a_ena, a_sel, a_num, a_vld, a_rd,
                             e.ena, e.sel, x_num, x_vld, e.rd);
            end
        end
    end

    logic [7:0] seq8 [9];
    logic [7:0] seq3 [9];

    // Stimulus.
    initial begin
        seq8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        seq3 = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04};
        nres = 1'b0;
        if8.cog_ena = 8'h00; if8.skip_en_ovr = 1'b0; if8.skip_en_val = 1'b0; if8.hold = 1'b0;
        if3.cog_ena = 8'hFF; if3.skip_en_ovr = 1'b0; if3.skip_en_val = 1'b0; if3.hold = 1'b0;

        // Held in reset across two edges.
        tick(); push(0, 1'b0, 8'h00, 1'b0); push(1, 1'b0, 8'h00, 1'b0);
        tick(); push(0, 1'b0, 8'h00, 1'b0); push(1, 1'b0, 8'h00, 1'b0);
        #2 nres = 1'b1;

        // Plain rotation on both instances.
        tick(); push(0, 1'b1, 8'h00, 1'b0); push(1, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 9; k++) begin
            tick();
            push(0, 1'b0, seq8[k], seq8[k] == 8'h01);
            push(1, 1'b0, seq3[k], seq3[k] == 8'h01);
            tick();
            push(0, 1'b1, seq8[k], 1'b0);
            push(1, 1'b1, seq3[k], 1'b0);
        end

        // Skip-idle with cogs 2 and 5 enabled, starting from slot 0.
        if8.skip_en_ovr = 1'b1; if8.skip_en_val = 1'b1; if8.cog_ena = 8'b0010_0100;
        adv(8'h04, 1'b0);
        adv(8'h20, 1'b0);
        adv(8'h04, 1'b1);
        adv(8'h20, 1'b0);
        adv(8'h04, 1'b1);

        // Nothing enabled: plain rotation resumes from slot 2.
        if8.cog_ena = 8'h00;
        adv(8'h08, 1'b0);

        // Hold across two advance edges.
        if8.hold = 1'b1;
        adv(8'h08, 1'b0);
        adv(8'h08, 1'b0);
        if8.hold = 1'b0;
        adv(8'h10, 1'b0);

        // Sole enabled cog keeps its slot and closes a round every advance.
        if8.cog_ena = 8'h01;
        adv(8'h01, 1'b1);
        adv(8'h01, 1'b1);
        adv(8'h01, 1'b1);

        // Back to plain rotation, run up to slot 6.
        if8.skip_en_ovr = 1'b0; if8.skip_en_val = 1'b0; if8.cog_ena = 8'h00;
        adv(8'h02, 1'b0);
        adv(8'h04, 1'b0);
        adv(8'h08, 1'b0);
        adv(8'h10, 1'b0);
        adv(8'h20, 1'b0);
        tick(); push(0, 1'b0, 8'h40, 1'b0);

        // Asynchronous reset between edges while bus_sel=40.
        tick();
        #2 nres = 1'b0;
        push(0, 1'b0, 8'h00, 1'b0);
        tick(); push(0, 1'b0, 8'h00, 1'b0);
        #2 nres = 1'b1;

        // Restart matches the power-on sequence.
        tick(); push(0, 1'b1, 8'h00, 1'b0);
        adv(8'h01, 1'b1);
        adv(8'h02, 1'b0);
        adv(8'h04, 1'b0);

        @(negedge clk_cog);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hub_slot_sched.md
# hub_slot_sched

Hub access scheduler that sits between the cog array and the hub. It generates the hub bus phase strobe and the one-hot cog slot select that every cog and the hub consume. It supports plain round-robin rotation over the populated cogs, an optional skip-idle mode that grants slots only to enabled cogs, and a hold input that freezes rotation for multi-window hub operations.

## Interface

Parameters:
- NUM_COGS, 8: populated cogs, 1..8; slots at or above NUM_COGS are never selected.
- SKIP_IDLE_DEFAULT, 0: value `skip_en` takes when the `skip_en_ovr` input is low.

Ports:
- clk_cog  in  1  cog clock; all state on rising edge.
- nres  in  1  reset, asynchronous, active-low.
- cog_ena  in  8  per-cog running flags from the hub; bits at or above NUM_COGS are ignored.
- skip_en_ovr  in  1  1 = use `skip_en_val` instead of SKIP_IDLE_DEFAULT.
- skip_en_val  in  1  skip-idle mode value when overridden.
- hold  in  1  freeze the slot on the next advance.
- ena_bus  out  1  hub phase strobe; toggles every clk_cog.
- bus_sel  out  8  one-hot slot select, or all-zero before the first advance.
- slot_num  out  3  binary index of the bus_sel bit; 0 when bus_sel is zero.
- round_done  out  1  one-cycle pulse when rotation wraps.
- slot_valid  out  1  1 when bus_sel is non-zero.

## Operation

- **Phase**
  - `ena_bus` resets to 0 and inverts on every clk_cog edge.
  - An "advance edge" is a clk_cog edge where `ena_bus` is 1 before the edge.
- **Advance, normal mode (skip_en=0)**
  - Reset state is bus_sel=0.
  - First advance selects cog 0.
  - Each later advance selects (cur+1) mod NUM_COGS.
- **Advance, skip-idle mode (skip_en=1)**
  - Search circularly from cur+1 for the first index < NUM_COGS with cog_ena set. The current index is included last, so a sole enabled cog keeps its slot.
  - If no populated cog is enabled, fall back to the normal-mode next index.
  - From the reset state, the search starts at index 0.
- **Mode sampling:** skip_en and cog_ena are sampled only at advance edges. Mode changes take effect on the next advance, with no glitch in bus_sel.
- **Hold**
  - hold=1 at an advance edge: bus_sel, slot_num and slot_valid keep their values, and round_done stays 0.
  - hold is ignored on non-advance edges.
  - hold while bus_sel=0 keeps bus_sel=0.
- **round_done:** asserted for exactly the clk_cog cycle after an advance whose new index ≤ old index, or the first advance from reset.
  - Covers the NUM_COGS=1 case and a sole enabled cog in skip mode: both pulse every advance.
- **Slot hold time:** bus_sel stays stable for 2 clk_cog cycles per slot (one full ena_bus period).
- **Reset mid-operation:** on nres low, all outputs go to reset values immediately (asynchronous). The first advance after release is the second clk_cog edge.

## Timing

- Reset values:
  - ena_bus=0, bus_sel=8'h00, slot_num=0, slot_valid=0, round_done=0.
- Edge sequence after reset release:
  - Edge 1: ena_bus→1.
  - Edge 2: advance; bus_sel=8'h01, round_done=1.
  - Edge 3: ena_bus→1, round_done→0.
  - Edge 4: advance, and so on.
- All outputs are registered with no combinational path from inputs.
  - cog_ena, skip_en and hold affect outputs one clk_cog edge after being sampled at an advance edge.
- Normal mode with NUM_COGS=8 gives a fixed 16-clk_cog hub window per cog. This is the same cadence the hub already assumes.

## Structure

- Shared package (`hub_pkg`):
  - HUB_SLOTS=8 and SLOT_W=3.
  - One-hot/index conversion functions, reused by the hub.
- One sub-module, `rr_next_finder`, is combinational.
  - Inputs: current index, 8-bit eligibility mask (cog_ena & populated-mask), start-from-reset flag.
  - Outputs: next index and a found flag.
- The top level holds the phase flop, slot register, round_done flop and the mode/hold muxing.

## Test plan

- Reset release, NUM_COGS=8, skip off:
  - bus_sel steps 01,02,04,…,80,01 every 2 clk_cog.
  - round_done pulses at the 01 entries only.
  - ena_bus alternates 0,1 starting with 1 at edge 1.
- NUM_COGS=3, skip off: bus_sel cycles 01,02,04,01; bits 3..7 are never set.
- Skip on, cog_ena=8'b0010_0100:
  - bus_sel alternates 04,20.
  - round_done pulses on each return to 04.
  - Switching cog_ena to 0 falls back to plain rotation from the current slot.
- hold=1 across two advance edges while bus_sel=08: bus_sel stays 08 for 6 clk_cog, then advances to 10 with no round_done.
- Skip on, cog_ena=8'b0000_0001: bus_sel stays 01 and round_done pulses every advance.
- Assert nres mid-rotation (bus_sel=40) between edges: all outputs are 0 immediately, and the restart matches the first scenario.
